// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and mode type for the universal shift register
// and any controller that drives it.
package univ_shift_reg_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned NUM_SRC = 8;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_SHL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_UP   = 3'b110;
  localparam mode_t MODE_DOWN = 3'b111;

endpackage

// File: rtl/univ_shift_reg_mux_dff_cell.sv
// One register bit: 8:1 next-state mux indexed by mode, synchronous clear,
// clock enable and an async-reset flop that resets to RESET_BIT.
module univ_shift_reg_mux_dff_cell
  import univ_shift_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  mode_t              i_mode,
  input  logic [NUM_SRC-1:0] i_src,
  output logic               o_q
);

  logic r_q;
  logic w_next;

  // clr beats enable; with enable low the bit holds
  always_comb begin
    w_next = r_q;
    if (i_clr) begin
      w_next = RESET_BIT;
    end else if (i_en) begin
      w_next = i_src[i_mode];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and up/down count,
// built from one mux/flop cell per bit plus shared neighbour and count vectors.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             tc
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic             w_all_ones;
  logic             w_all_zero;

  assign w_inc = w_q + WIDTH'(1);
  assign w_dec = w_q - WIDTH'(1);
  assign w_shr = {sin_l, w_q[WIDTH-1:1]};
  assign w_shl = {w_q[WIDTH-2:0], sin_r};
  assign w_ror = {w_q[0], w_q[WIDTH-1:1]};
  assign w_rol = {w_q[WIDTH-2:0], w_q[WIDTH-1]};

  // Source order matches the mode encoding: bit n of i_src is mode n
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_shift_reg_mux_dff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (clr),
      .i_en   (en),
      .i_mode (mode),
      .i_src  ({w_dec[i], w_inc[i], w_rol[i], w_ror[i],
                w_shl[i], w_shr[i], d[i],     w_q[i]}),
      .o_q    (w_q[i])
    );
  end

  assign w_all_ones = &w_q;
  assign w_all_zero = ~(|w_q);

  assign q      = w_q;
  assign sout_r = w_q[0];
  assign sout_l = w_q[WIDTH-1];

  // High exactly when the coming edge wraps the counter
  assign tc = en & ~clr & (((mode == MODE_UP)   & w_all_ones) |
                           ((mode == MODE_DOWN) & w_all_zero));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg at WIDTH 8, 2 and 16; table rows and hand sequences
// feed a scoreboard of expected q values checked one edge later.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mode_t       mode;
  logic [15:0] d;
  logic        sin_l, sin_r;
  logic        en8, en2, en16, clr8, clr2, clr16;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic        sr8, sl8, tc8, sr2, sl2, tc2, sr16, sl16, tc16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .en(en8), .mode(mode), .d(d[7:0]),
    .sin_l(sin_l), .sin_r(sin_r), .q(q8), .sout_r(sr8), .sout_l(sl8), .tc(tc8)
  );

  univ_shift_reg #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .en(en2), .mode(mode), .d(d[1:0]),
    .sin_l(sin_l), .sin_r(sin_r), .q(q2), .sout_r(sr2), .sout_l(sl2), .tc(tc2)
  );

  univ_shift_reg #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr16), .en(en16), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q16), .sout_r(sr16), .sout_l(sl16), .tc(tc16)
  );

  typedef struct {
    int          sel;
    logic        clr;
    logic        en;
    mode_t       mode;
    logic [15:0] d;
    logic        sin_l;
    logic        sin_r;
    logic [15:0] exp_q;
    logic        exp_tc;
    logic        exp_sr;
    logic        exp_sl;
  } vec_t;

  typedef struct {
    int          sel;
    logic [15:0] exp_q;
    int          idx;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];

  function automatic vec_t mk(input int sel, input logic c, input logic e,
                              input mode_t m, input logic [15:0] dd,
                              input logic sl, input logic sr,
                              input logic [15:0] eq, input logic etc,
                              input logic esr, input logic esl);
    vec_t v;
    v.sel = sel; v.clr = c; v.en = e; v.mode = m; v.d = dd;
    v.sin_l = sl; v.sin_r = sr; v.exp_q = eq; v.exp_tc = etc;
    v.exp_sr = esr; v.exp_sl = esl;
    return v;
  endfunction

  function automatic logic [15:0] get_q(input int sel);
    case (sel)
      0:       return {8'h00, q8};
      1:       return {14'h0000, q2};
      default: return q16;
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int sel);
    case (sel)
      0:       return {tc8, sr8, sl8};
      1:       return {tc2, sr2, sl2};
      default: return {tc16, sr16, sl16};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en8 = 1'b0; en2 = 1'b0; en16 = 1'b0;
    clr8 = 1'b0; clr2 = 1'b0; clr16 = 1'b0;
    mode = MODE_HOLD;
  endtask

  // Drive one vector, check combinational outputs pre-edge, q one edge later
  task automatic apply(input vec_t v, input int idx);
    logic [2:0] f;
    sb_t        e;
    @(negedge clk);
    mode = v.mode; d = v.d; sin_l = v.sin_l; sin_r = v.sin_r;
    en8   = (v.sel == 0) && v.en;  clr8  = (v.sel == 0) && v.clr;
    en2   = (v.sel == 1) && v.en;  clr2  = (v.sel == 1) && v.clr;
    en16  = (v.sel == 2) && v.en;  clr16 = (v.sel == 2) && v.clr;
    #1;
    f = get_flags(v.sel);
    check($sformatf("v%0d tc", idx),     {15'h0, f[2]}, {15'h0, v.exp_tc});
    check($sformatf("v%0d sout_r", idx), {15'h0, f[1]}, {15'h0, v.exp_sr});
    check($sformatf("v%0d sout_l", idx), {15'h0, f[0]}, {15'h0, v.exp_sl});
    sb_q.push_back('{v.sel, v.exp_q, idx});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d scoreboard empty", idx), 16'h0001, 16'h0000);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("v%0d q", e.idx), get_q(e.sel), e.exp_q);
    end
  endtask

  initial begin
    logic [7:0] m;
    vec_t       v;

    rst_n = 1'b0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    idle_inputs();

    // W8 rows: sel clr en mode d sin_l sin_r exp_q exp_tc sr sl (flags pre-edge)
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h00A5,0,0,16'h00A5,0,0,0));
    tbl.push_back(mk(0,0,1,MODE_SHR, 16'h0000,1,0,16'h00D2,0,1,1));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h00A5,0,0,16'h00A5,0,0,1));
    tbl.push_back(mk(0,0,1,MODE_SHL, 16'h0000,0,0,16'h004A,0,1,1));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h0081,0,0,16'h0081,0,0,0));
    tbl.push_back(mk(0,0,1,MODE_ROR, 16'h0000,0,0,16'h00C0,0,1,1));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h0081,0,0,16'h0081,0,0,1));
    tbl.push_back(mk(0,0,1,MODE_ROL, 16'h0000,0,0,16'h0003,0,1,1));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h00FE,0,0,16'h00FE,0,1,0));
    tbl.push_back(mk(0,0,1,MODE_UP,  16'h0000,0,0,16'h00FF,0,0,1));
    tbl.push_back(mk(0,0,1,MODE_UP,  16'h0000,0,0,16'h0000,1,1,1));
    tbl.push_back(mk(0,0,1,MODE_DOWN,16'h0000,0,0,16'h00FF,1,0,0));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h0055,0,0,16'h0055,0,1,1));
    tbl.push_back(mk(0,0,0,MODE_LOAD,16'h00FF,0,0,16'h0055,0,1,0));
    tbl.push_back(mk(0,1,1,MODE_UP,  16'h0000,0,0,16'h0000,0,1,0));
    tbl.push_back(mk(0,0,1,MODE_HOLD,16'h00FF,1,1,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,1,MODE_LOAD,16'h00FF,0,0,16'h00FF,0,0,0));
    tbl.push_back(mk(0,0,0,MODE_UP,  16'h0000,0,0,16'h00FF,0,1,1));
    tbl.push_back(mk(0,1,1,MODE_UP,  16'h0000,0,0,16'h0000,0,1,1));
    tbl.push_back(mk(0,1,1,MODE_DOWN,16'h0000,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,1,MODE_DOWN,16'h0000,0,0,16'h00FF,1,0,0));
    // W2 rows
    tbl.push_back(mk(1,0,1,MODE_LOAD,16'h0002,0,0,16'h0002,0,0,0));
    tbl.push_back(mk(1,0,1,MODE_UP,  16'h0000,0,0,16'h0003,0,0,1));
    tbl.push_back(mk(1,0,1,MODE_UP,  16'h0000,0,0,16'h0000,1,1,1));
    tbl.push_back(mk(1,0,1,MODE_DOWN,16'h0000,0,0,16'h0003,1,0,0));
    tbl.push_back(mk(1,0,1,MODE_LOAD,16'h0002,0,0,16'h0002,0,1,1));
    tbl.push_back(mk(1,0,1,MODE_ROL, 16'h0000,0,0,16'h0001,0,0,1));
    tbl.push_back(mk(1,0,1,MODE_ROL, 16'h0000,0,0,16'h0002,0,1,0));
    // W16 rows
    tbl.push_back(mk(2,0,1,MODE_LOAD,16'hFFFE,0,0,16'hFFFE,0,0,0));
    tbl.push_back(mk(2,0,1,MODE_UP,  16'h0000,0,0,16'hFFFF,0,0,1));
    tbl.push_back(mk(2,0,1,MODE_UP,  16'h0000,0,0,16'h0000,1,1,1));
    tbl.push_back(mk(2,0,1,MODE_DOWN,16'h0000,0,0,16'hFFFF,1,0,0));
    tbl.push_back(mk(2,0,1,MODE_LOAD,16'h8001,0,0,16'h8001,0,1,1));
    tbl.push_back(mk(2,0,1,MODE_ROL, 16'h0000,0,0,16'h0003,0,1,1));

    // Reset held with the clock running
    repeat (3) @(posedge clk);
    #1;
    check("rst q8",  get_q(0), 16'h0000);
    check("rst q2",  get_q(1), 16'h0000);
    check("rst q16", get_q(2), 16'h0000);
    check("rst tc8", {15'h0, tc8}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of an UP count
    apply(mk(0,0,1,MODE_LOAD,16'h0037,0,0,16'h0037,0,0,0), 100);
    @(negedge clk);
    mode = MODE_UP; en8 = 1'b1;
    #1;
    check("midrst tc pre", {15'h0, tc8}, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst q", get_q(0), 16'h0000);
    check("midrst sout_l", {15'h0, sl8}, 16'h0000);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst q after edge", get_q(0), 16'h0000);

    foreach (tbl[i]) apply(tbl[i], i);

    // Eight RORs must return to the starting pattern
    apply(mk(0,0,1,MODE_LOAD,16'h0081,0,0,16'h0081,0,1,1), 200);
    m = 8'h81;
    for (int k = 0; k < 8; k++) begin
      v = mk(0,0,1,MODE_ROR,16'h0000,0,0,{8'h00, m[0], m[7:1]},0,m[0],m[7]);
      m = {m[0], m[7:1]};
      apply(v, 300 + k);
    end
    check("ror8 back to 81", get_q(0), 16'h0081);

    @(negedge clk);
    idle_inputs();
    check("scoreboard drained", 16'(sb_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
